// File: rtl/alu_core.sv
// 32-bit signed ALU for the execute stage: eight logic/arithmetic functions
// with a registered result and a registered signed add/subtract overflow flag.
module alu_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic [2:0]  aluop,
    output logic [31:0] alu_out,
    output logic        add_sub_overflow
);

    typedef enum logic [2:0] {
        OP_NEG = 3'b000,
        OP_AND = 3'b001,
        OP_XOR = 3'b010,
        OP_OR  = 3'b011,
        OP_DEC = 3'b100,
        OP_ADD = 3'b101,
        OP_SUB = 3'b110,
        OP_INC = 3'b111
    } aluop_e;

    aluop_e      w_op;
    logic [31:0] w_result;
    logic        w_overflow;
    logic [31:0] r_alu_out;
    logic        r_overflow;

    assign w_op = aluop_e'(aluop);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch is inferred.
        w_result   = '0;
        w_overflow = 1'b0;
        unique case (w_op)
            OP_NEG: w_result = 32'd0 - operand1;
            OP_AND: w_result = operand1 & operand2;
            OP_XOR: w_result = operand1 ^ operand2;
            OP_OR:  w_result = operand1 | operand2;
            OP_DEC: w_result = operand1 - 32'd1;
            OP_ADD: begin
                w_result   = operand1 + operand2;
                // Same-sign operands producing an opposite-sign sum.
                w_overflow = (operand1[31] == operand2[31]) && (w_result[31] != operand1[31]);
            end
            OP_SUB: begin
                w_result   = operand1 - operand2;
                w_overflow = (operand1[31] != operand2[31]) && (w_result[31] != operand1[31]);
            end
            OP_INC: w_result = operand1 + 32'd1;
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_out  <= '0;
            r_overflow <= 1'b0;
        end else begin
            // NOTE: non-blocking so both flops update together from this cycle's inputs.
            r_alu_out  <= w_result;
            r_overflow <= w_overflow;
        end
    end

    assign alu_out          = r_alu_out;
    assign add_sub_overflow = r_overflow;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed vectors with hand-derived
// expectations plus a randomized run against a wide-integer reference model.
module tb_alu_core;

    logic        clk;
    logic        rst_n;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [2:0]  aluop;
    logic [31:0] alu_out;
    logic        add_sub_overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_res;
    logic        exp_ovf;

    alu_core dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .operand1         (operand1),
        .operand2         (operand2),
        .aluop            (aluop),
        .alu_out          (alu_out),
        .add_sub_overflow (add_sub_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: evaluate in 64-bit signed arithmetic, truncate, and flag
    // ADD/SUB whose exact result falls outside the 32-bit signed range.
    function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] op,
                                    output logic [31:0] r, output logic ovf);
        longint sa;
        longint sb;
        longint full;
        logic [63:0] bits;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        full = 0;
        case (op)
            3'd0: full = -sa;
            3'd1: full = longint'($signed(a & b));
            3'd2: full = longint'($signed(a ^ b));
            3'd3: full = longint'($signed(a | b));
            3'd4: full = sa - 1;
            3'd5: full = sa + sb;
            3'd6: full = sa - sb;
            default: full = sa + 1;
        endcase
        bits = 64'(full);
        r    = bits[31:0];
        ovf  = (op == 3'd5 || op == 3'd6) &&
               (full > 64'sd2147483647 || full < -64'sd2147483648);
    endfunction

    // Apply one operation on the falling edge and record the model's answer.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        @(negedge clk);
        operand1 = a;
        operand2 = b;
        aluop    = op;
        ref_alu(a, b, op, exp_res, exp_ovf);
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        drive(32'h1234_5678, 32'h0101_0101, 3'd5);
        @(posedge clk); #1;
        n_checks++;
        if (alu_out !== exp_res || add_sub_overflow !== exp_ovf) begin
            n_errors++;
            $display("FAIL pre_reset_op: got %h/%b want %h/%b", alu_out, add_sub_overflow, exp_res, exp_ovf);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (alu_out !== 32'h0 || add_sub_overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: got %h/%b want 00000000/0", alu_out, add_sub_overflow);
        end
        @(posedge clk); #1;
        n_checks++;
        if (alu_out !== 32'h0 || add_sub_overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_hold: got %h/%b want 00000000/0", alu_out, add_sub_overflow);
        end
        drive(32'h7FFF_FFFF, 32'h0000_0001, 3'd5);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (alu_out !== 32'h8000_0000 || add_sub_overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL first_after_reset: got %h/%b want 80000000/1", alu_out, add_sub_overflow);
        end
    endtask

    task automatic test_sweep;
        logic [31:0] want [8];
        want = '{32'hFFFF_FFE0, 32'h0000_0020, 32'h0000_0002, 32'h0000_0022,
                 32'h0000_001F, 32'h0000_0042, 32'hFFFF_FFFE, 32'h0000_0021};
        for (int i = 0; i < 8; i++) begin
            drive(32'd32, 32'd34, 3'(i));
            @(posedge clk); #1;
            n_checks++;
            if (alu_out !== want[i] || add_sub_overflow !== 1'b0) begin
                n_errors++;
                $display("FAIL sweep_op%0d: got %h/%b want %h/0", i, alu_out, add_sub_overflow, want[i]);
            end
        end
    endtask

    task automatic test_overflow;
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic [2:0]  vop [8];
        logic [31:0] vr [8];
        logic        vf [8];
        va  = '{32'h7FFF_FFFF, 32'h0000_0005, 32'h7FFF_FFFF, 32'h8000_0000,
                32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000};
        vb  = '{32'h0000_0001, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0000_0001,
                32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vop = '{3'd5, 3'd5, 3'd6, 3'd6, 3'd6, 3'd7, 3'd4, 3'd0};
        vr  = '{32'h8000_0000, 32'h0000_0002, 32'h8000_0000, 32'h7FFF_FFFF,
                32'h8000_0001, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000};
        vf  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            drive(va[i], vb[i], vop[i]);
            @(posedge clk); #1;
            n_checks++;
            if (alu_out !== vr[i] || add_sub_overflow !== vf[i]) begin
                n_errors++;
                $display("FAIL boundary_%0d (op %0d): got %h/%b want %h/%b",
                         i, vop[i], alu_out, add_sub_overflow, vr[i], vf[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int          rst_at;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        rst_at = int'($urandom_range(200, 800));
        for (int i = 0; i < 1000; i++) begin
            a  = $urandom;
            b  = $urandom;
            op = 3'($urandom_range(0, 7));
            if (i % 50 == 7) a = (i % 100 == 7) ? 32'h7FFF_FFFF : 32'h8000_0000;
            drive(a, b, op);
            rst_n = (i == rst_at) ? 1'b0 : 1'b1;
            if (i == rst_at) begin
                #1;
                n_checks++;
                if (alu_out !== 32'h0 || add_sub_overflow !== 1'b0) begin
                    n_errors++;
                    $display("FAIL rand_async_reset: got %h/%b want 00000000/0", alu_out, add_sub_overflow);
                end
                exp_res = 32'h0;
                exp_ovf = 1'b0;
            end
            @(posedge clk); #1;
            n_checks++;
            if (alu_out !== exp_res || add_sub_overflow !== exp_ovf) begin
                n_errors++;
                $display("FAIL rand_%0d (A=%h B=%h op=%0d): got %h/%b want %h/%b",
                         i, a, b, op, alu_out, add_sub_overflow, exp_res, exp_ovf);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        operand1 = '0;
        operand2 = '0;
        aluop    = '0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_sweep();
        test_overflow();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
